// File: rtl/fifo_param_sync_pkg.sv
// Shared configuration for the parametrised FIFO: default sizes, pointer width and parameter legality.
package fifo_cfg_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Legal when DEPTH is a power of two >= 4 and both thresholds are inside the occupancy range.
  function automatic bit cfg_ok(input int data_w, input int depth, input int af_level, input int ae_level);
    return (data_w >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_param_sync_if.sv
// Producer/consumer-side bundle of the FIFO: master drives requests, slave is the FIFO itself.
interface fifo_param_sync_if
  import fifo_cfg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  logic                     clr;
  logic                     wr_en;
  logic [DATA_W-1:0]        wr_data;
  logic                     rd_en;
  logic [DATA_W-1:0]        rd_data;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param_sync_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port; contents are never reset.
module fifo_ram
  import fifo_cfg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];
endmodule

// File: rtl/fifo_param_sync.sv
// Parametrised single-clock FIFO: pointers, occupancy, flags and read-mode logic around fifo_ram.
module fifo_param_sync
  import fifo_cfg_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  fifo_param_sync_if.slave bus
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  if (!cfg_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_cfg_err
    $error("fifo_param_sync: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r, count_nxt_s;
  logic              full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
  logic              wr_acc_s, rd_acc_s;
  logic [DATA_W-1:0] ram_rd_s;

  // Acceptance uses the registered flags; clr masks both requests.
  always_comb begin
    wr_acc_s    = bus.wr_en & ~full_r & ~bus.clr;
    rd_acc_s    = bus.rd_en & ~empty_r & ~bus.clr;
    count_nxt_s = count_r;
    if (bus.clr) begin
      count_nxt_s = CNT_ZERO;
    end else if (wr_acc_s & ~rd_acc_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (rd_acc_s & ~wr_acc_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointer advance; natural wrap at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (bus.clr) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      wr_ptr_r <= wr_acc_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
      rd_ptr_r <= rd_acc_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
    end
  end

  // Occupancy and flags, derived from next count so they move with the accepted operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == CNT_ZERO);
      af_r    <= (count_nxt_s >= CNT_AF);
      ae_r    <= (count_nxt_s <= CNT_AE);
      ovf_r   <= bus.wr_en & full_r & ~bus.clr;
      unf_r   <= bus.rd_en & empty_r & ~bus.clr;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wr_ptr_r),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_r),
    .rdata (ram_rd_s)
  );

  if (FWFT) begin : g_fwft
    assign bus.rd_data = ram_rd_s;
  end else begin : g_std
    logic [DATA_W-1:0] rd_data_r;

    // Registered read: load the head on an accepted read, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_r <= {DATA_W{1'b0}};
      end else if (rd_acc_s) begin
        rd_data_r <= ram_rd_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end

    assign bus.rd_data = rd_data_r;
  end

  assign bus.count        = count_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;
endmodule

// File: tb/tb_fifo_param_sync.sv
// Bench: standard-mode and FWFT FIFOs driven in lockstep, checked against a queue model every cycle.
module tb_fifo_param_sync;
  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = 8'h00;

  int total = 0;
  int bad   = 0;

  fifo_param_sync_if #(.DATA_W(DW), .DEPTH(DP)) if_s ();
  fifo_param_sync_if #(.DATA_W(DW), .DEPTH(DP)) if_f ();

  assign if_s.clr = clr;  assign if_s.wr_en = wr_en;  assign if_s.rd_en = rd_en;  assign if_s.wr_data = wr_data;
  assign if_f.clr = clr;  assign if_f.wr_en = wr_en;  assign if_f.rd_en = rd_en;  assign if_f.wr_data = wr_data;

  fifo_param_sync #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(DP-2), .AE_LEVEL(2), .FWFT(1'b0))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));
  fifo_param_sync #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(DP-2), .AE_LEVEL(2), .FWFT(1'b1))
    dut_f (.clk(clk), .rst_n(rst_n), .bus(if_f.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus last-read word and pulse flags.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd = 8'h00;
  bit            m_ov = 1'b0;
  bit            m_un = 1'b0;

  initial begin : model
    int n;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_rd = 8'h00;
        m_ov = 1'b0;
        m_un = 1'b0;
      end else if (clr) begin
        q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
      end else begin
        n    = q.size();
        m_ov = wr_en && (n == DP);
        m_un = rd_en && (n == 0);
        if (rd_en && n > 0) m_rd = q.pop_front();
        if (wr_en && n < DP) q.push_back(wr_data);
      end
    end
  end

  // Cycle-by-cycle compare of both DUTs against the model
  initial begin : compare
    int n;
    forever begin
      @(negedge clk);
      n = q.size();
      chk("std.count", 32'(if_s.count), 32'(n));
      chk("std.full", 32'(if_s.full), 32'(n == DP));
      chk("std.empty", 32'(if_s.empty), 32'(n == 0));
      chk("std.almost_full", 32'(if_s.almost_full), 32'(n >= DP - 2));
      chk("std.almost_empty", 32'(if_s.almost_empty), 32'(n <= 2));
      chk("std.overflow", 32'(if_s.overflow), 32'(m_ov));
      chk("std.underflow", 32'(if_s.underflow), 32'(m_un));
      chk("std.rd_data", 32'(if_s.rd_data), 32'(m_rd));
      chk("fwft.count", 32'(if_f.count), 32'(n));
      chk("fwft.empty", 32'(if_f.empty), 32'(n == 0));
      chk("fwft.full", 32'(if_f.full), 32'(n == DP));
      chk("fwft.overflow", 32'(if_f.overflow), 32'(m_ov));
      chk("fwft.underflow", 32'(if_f.underflow), 32'(m_un));
      if (n > 0) chk("fwft.rd_data", 32'(if_f.rd_data), 32'(q[0]));
    end
  end

  // One clock of stimulus; returns at the following falling edge.
  task automatic step(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    wr_en = w; rd_en = r; clr = c; wr_data = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : stim
    logic [DW-1:0] held;
    repeat (2) @(negedge clk);
    chk("reset.empty", 32'(if_s.empty), 32'd1);
    chk("reset.almost_empty", 32'(if_s.almost_empty), 32'd1);
    chk("reset.count", 32'(if_s.count), 32'd0);
    chk("reset.rd_data", 32'(if_s.rd_data), 32'h00);
    rst_n = 1'b1;

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i));
      if (i == 13) chk("fill.af_at13", 32'(if_s.almost_full), 32'd0);
      if (i == 14) chk("fill.af_at14", 32'(if_s.almost_full), 32'd1);
    end
    chk("fill.full", 32'(if_s.full), 32'd1);
    chk("fill.count", 32'(if_s.count), 32'd16);
    chk("fill.fwft_head", 32'(if_f.rd_data), 32'h01);
    step(1'b1, 1'b0, 1'b0, 8'h11);
    chk("ovf.pulse", 32'(if_s.overflow), 32'd1);
    chk("ovf.count", 32'(if_s.count), 32'd16);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf.cleared", 32'(if_s.overflow), 32'd0);

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain.rd_data", 32'(if_s.rd_data), 32'(i));
    end
    chk("drain.empty", 32'(if_s.empty), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("unf.pulse", 32'(if_s.underflow), 32'd1);
    chk("unf.rd_hold", 32'(if_s.rd_data), 32'h10);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("unf.back_to_back", 32'(if_s.underflow), 32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("unf.cleared", 32'(if_s.underflow), 32'd0);

    // FWFT: single word into empty is visible without rd_en
    step(1'b1, 1'b0, 1'b0, 8'hA5);
    chk("fwft.a5_data", 32'(if_f.rd_data), 32'hA5);
    chk("fwft.a5_empty", 32'(if_f.empty), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fwft.pop_empty", 32'(if_f.empty), 32'd1);

    // Sustained simultaneous traffic at count 8, wrapping pointers
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h28 + i));
    chk("stream.count", 32'(if_s.count), 32'd8);
    chk("stream.last_read", 32'(if_s.rd_data), 32'(8'h28 + 31));

    // Full with both requests: read taken, write rejected
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    chk("full_both.count", 32'(if_s.count), 32'd15);
    chk("full_both.overflow", 32'(if_s.overflow), 32'd1);
    chk("full_both.rd_data", 32'(if_s.rd_data), 32'(8'h28 + 32));
    step(1'b1, 1'b0, 1'b0, 8'hEF);
    chk("refill.count", 32'(if_s.count), 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drain2.last", 32'(if_s.rd_data), 32'hEF);

    // Empty with both requests: write taken, read rejected
    step(1'b1, 1'b1, 1'b0, 8'h3C);
    chk("empty_both.count", 32'(if_s.count), 32'd1);
    chk("empty_both.underflow", 32'(if_s.underflow), 32'd1);
    chk("empty_both.fwft_data", 32'(if_f.rd_data), 32'h3C);

    // Synchronous clear at count 9 with a write pending
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h70 + i));
    chk("pre_clr.count", 32'(if_s.count), 32'd9);
    held = if_s.rd_data;
    step(1'b1, 1'b0, 1'b1, 8'h99);
    chk("clr.count", 32'(if_s.count), 32'd0);
    chk("clr.empty", 32'(if_s.empty), 32'd1);
    chk("clr.overflow", 32'(if_s.overflow), 32'd0);
    chk("clr.rd_hold", 32'(if_s.rd_data), 32'(8'hEF));
    chk("clr.rd_hold_sampled", 32'(if_s.rd_data), 32'(held));

    // Async reset in the middle of a burst
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    wr_en = 1'b1; wr_data = 8'h90;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.count", 32'(if_s.count), 32'd0);
    chk("arst.empty", 32'(if_s.empty), 32'd1);
    chk("arst.full", 32'(if_s.full), 32'd0);
    chk("arst.almost_empty", 32'(if_s.almost_empty), 32'd1);
    chk("arst.almost_full", 32'(if_s.almost_full), 32'd0);
    chk("arst.rd_data", 32'(if_s.rd_data), 32'h00);
    chk("arst.overflow", 32'(if_s.overflow), 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h42);
    chk("post_rst.count", 32'(if_s.count), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_rst.rd_data", 32'(if_s.rd_data), 32'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
